// File: rtl/sn7404_test_sequencer.sv
// ============================================================================
//  Module   : sn7404_test_sequencer
//  Purpose  : Powers an SN7404 socket, checks all 64 input vectors and an
//             unpowered hold check, then reports pass/fail and a gate mask.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sn7404_test_sequencer #(
    parameter int POWER_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CHECK    = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    output logic       DUT_VCC,
    output logic       DUT_GND,
    output logic [5:0] DUT_IN,
    input  logic [5:0] DUT_OUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [5:0] FAIL_MASK,
    output logic [6:0] VEC_COUNT
);

    localparam int c_CNT_MAX = (POWER_CYCLES > SETTLE_CYCLES) ? POWER_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_POWER_LAST  = c_CNT_W'(POWER_CYCLES);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic c_HAS_SETTLE = (SETTLE_CYCLES > 0);
    localparam logic c_HOLD_EN    = (HOLD_CHECK != 0);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_POWER        = 4'd1,
        ST_DRIVE        = 4'd2,
        ST_SETTLE       = 4'd3,
        ST_CHECK        = 4'd4,
        ST_HOLD_DRIVE   = 4'd5,
        ST_HOLD_SETTLE  = 4'd6,
        ST_HOLD_CHECK_S = 4'd7,
        ST_DONE         = 4'd8
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [5:0]           r_vec, w_vec_nxt;
    logic [5:0]           r_dut_in, w_dut_in_nxt;
    logic                 r_vcc, w_vcc_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_pass, w_pass_nxt;
    logic [5:0]           r_fail_mask, w_fail_mask_nxt;
    logic [6:0]           r_vec_count, w_vec_count_nxt;

    logic [5:0]           w_expect;
    logic [5:0]           w_mismatch;
    logic [5:0]           w_mask_merged;

    // Outside CHECK the only compare is the hold check, which expects the
    // all-zero outputs retained from vector 63.
    assign w_expect = (r_state == ST_CHECK) ? ~r_vec : 6'b000000;

    // Case-inequality so an X or Z on a socket pin is flagged as a failure.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_cmp
            assign w_mismatch[gi] = (DUT_OUT[gi] !== w_expect[gi]);
        end
    endgenerate

    assign w_mask_merged = r_fail_mask | w_mismatch;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_vec_nxt       = r_vec;
        w_dut_in_nxt    = r_dut_in;
        w_vcc_nxt       = r_vcc;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_vec_count_nxt = r_vec_count;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt     = ST_POWER;
                    w_cnt_nxt       = '0;
                    w_vec_nxt       = 6'd0;
                    w_fail_mask_nxt = 6'd0;
                    w_vec_count_nxt = 7'd0;
                    w_pass_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_vcc_nxt       = 1'b1;
                end
            end
            ST_POWER: begin
                if (r_cnt == c_POWER_LAST) begin
                    w_state_nxt  = ST_DRIVE;
                    w_dut_in_nxt = r_vec;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                w_cnt_nxt = '0;
                if (c_HAS_SETTLE) w_state_nxt = ST_SETTLE;
                else              w_state_nxt = ST_CHECK;
            end
            ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) w_state_nxt = ST_CHECK;
                else                        w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_CHECK: begin
                w_fail_mask_nxt = w_mask_merged;
                w_vec_count_nxt = r_vec_count + 7'd1;
                if (r_vec == 6'd63) begin
                    w_vec_nxt = 6'd0;
                    if (c_HOLD_EN) begin
                        w_state_nxt  = ST_HOLD_DRIVE;
                        w_vcc_nxt    = 1'b0;
                        w_dut_in_nxt = 6'd0;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_vcc_nxt   = 1'b0;
                        w_pass_nxt  = (w_mask_merged == 6'd0);
                    end
                end else begin
                    w_vec_nxt    = r_vec + 6'd1;
                    w_dut_in_nxt = r_vec + 6'd1;
                    w_state_nxt  = ST_DRIVE;
                end
            end
            ST_HOLD_DRIVE: begin
                w_cnt_nxt = '0;
                if (c_HAS_SETTLE) w_state_nxt = ST_HOLD_SETTLE;
                else              w_state_nxt = ST_HOLD_CHECK_S;
            end
            ST_HOLD_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) w_state_nxt = ST_HOLD_CHECK_S;
                else                        w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_HOLD_CHECK_S: begin
                w_fail_mask_nxt = w_mask_merged;
                w_state_nxt     = ST_DONE;
                w_done_nxt      = 1'b1;
                w_busy_nxt      = 1'b0;
                w_vcc_nxt       = 1'b0;
                w_pass_nxt      = (w_mask_merged == 6'd0);
            end
            ST_DONE: begin
                w_state_nxt  = ST_IDLE;
                w_dut_in_nxt = 6'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_vec       <= 6'd0;
            r_dut_in    <= 6'd0;
            r_vcc       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 6'd0;
            r_vec_count <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_vec       <= w_vec_nxt;
            r_dut_in    <= w_dut_in_nxt;
            r_vcc       <= w_vcc_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_vec_count <= w_vec_count_nxt;
        end
    end

    assign DUT_VCC   = r_vcc;
    assign DUT_GND   = 1'b0;
    assign DUT_IN    = r_dut_in;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign FAIL_MASK = r_fail_mask;
    assign VEC_COUNT = r_vec_count;

endmodule

`default_nettype wire

// File: tb/tb_sn7404_test_sequencer.sv
// ============================================================================
//  Module   : tb_sn7404_test_sequencer
//  Purpose  : Self-checking bench with behavioural sockets and a vector-level
//             reference model for two parameterisations of the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sn7404_test_sequencer;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       a_start = 1'b0, b_start = 1'b0;
    logic       a_vcc, a_gnd, a_busy, a_done, a_pass;
    logic       b_vcc, b_gnd, b_busy, b_done, b_pass;
    logic [5:0] a_din, a_dout, a_mask, b_din, b_dout, b_mask;
    logic [6:0] a_cnt, b_cnt;
    logic [5:0] a_keep = 6'd0, b_keep = 6'd0;
    logic [5:0] a_s0 = 6'd0, a_s1 = 6'd0, b_s0 = 6'd0, b_s1 = 6'd0;
    logic       a_inv = 1'b0, b_inv = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 CLK = ~CLK;

    sn7404_test_sequencer u_dut_a (
        .CLK(CLK), .RESET(RESET), .START(a_start),
        .DUT_VCC(a_vcc), .DUT_GND(a_gnd), .DUT_IN(a_din), .DUT_OUT(a_dout),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
        .FAIL_MASK(a_mask), .VEC_COUNT(a_cnt)
    );

    sn7404_test_sequencer #(.POWER_CYCLES(4), .SETTLE_CYCLES(0), .HOLD_CHECK(0)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .START(b_start),
        .DUT_VCC(b_vcc), .DUT_GND(b_gnd), .DUT_IN(b_din), .DUT_OUT(b_dout),
        .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
        .FAIL_MASK(b_mask), .VEC_COUNT(b_cnt)
    );

    // Sockets: powered gates invert, unpowered gates keep their last output;
    // the inverter variant ignores power, stuck pins override everything.
    always @(posedge CLK) begin
        if (a_vcc) a_keep <= ~a_din;
        if (b_vcc) b_keep <= ~b_din;
    end

    always_comb begin
        a_dout = (((a_inv | a_vcc) ? ~a_din : a_keep) & ~a_s0) | a_s1;
        b_dout = (((b_inv | b_vcc) ? ~b_din : b_keep) & ~b_s0) | b_s1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 0) a_start = v;
        else        b_start = v;
    endtask

    task automatic set_fault(input int w, input logic [5:0] s0, input logic [5:0] s1, input logic inv);
        if (w == 0) begin a_s0 = s0; a_s1 = s1; a_inv = inv; end
        else        begin b_s0 = s0; b_s1 = s1; b_inv = inv; end
    endtask

    task automatic sample(input int w, output logic busy, output logic done, output logic vcc,
                          output logic gnd, output logic pass, output logic [5:0] din,
                          output logic [5:0] mask, output logic [6:0] cnt);
        if (w == 0) begin
            busy = a_busy; done = a_done; vcc = a_vcc; gnd = a_gnd;
            pass = a_pass; din = a_din; mask = a_mask; cnt = a_cnt;
        end else begin
            busy = b_busy; done = b_done; vcc = b_vcc; gnd = b_gnd;
            pass = b_pass; din = b_din; mask = b_mask; cnt = b_cnt;
        end
    endtask

    // Gate-level expectation: every pattern, then the retained-output check.
    function automatic logic [5:0] model_mask(input logic [5:0] s0, input logic [5:0] s1,
                                              input logic inv, input int h);
        logic [5:0] m, v, o, hold;
        m = 6'd0;
        for (int k = 0; k < 64; k++) begin
            v = 6'(k);
            o = (~v & ~s0) | s1;
            m = m | (o ^ ~v);
        end
        if (h != 0) begin
            hold = inv ? 6'h3F : ~6'd63;
            hold = (hold & ~s0) | s1;
            m = m | hold;
        end
        return m;
    endfunction

    task automatic check_reset_values(input int w, input string tag);
        logic busy, done, vcc, gnd, pass;
        logic [5:0] din, mask;
        logic [6:0] cnt;
        sample(w, busy, done, vcc, gnd, pass, din, mask, cnt);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_vcc"},  32'(vcc),  32'd0);
        check_val({tag, "_gnd"},  32'(gnd),  32'd0);
        check_val({tag, "_pass"}, 32'(pass), 32'd0);
        check_val({tag, "_din"},  32'(din),  32'd0);
        check_val({tag, "_mask"}, 32'(mask), 32'd0);
        check_val({tag, "_cnt"},  32'(cnt),  32'd0);
    endtask

    // One complete run; START is set now and sampled at the next edge (edge 0).
    task automatic run_check(input int w, input int p, input int s, input int h,
                             input logic [5:0] s0, input logic [5:0] s1_raw,
                             input logic inv, input logic held);
        int d, v_end, din_end, first_done, idx, n_done;
        int err_busy, err_vcc, err_din;
        logic busy, done, vcc, gnd, pass;
        logic [5:0] din, mask, din_exp, m_exp, s1;
        logic [6:0] cnt;
        logic vcc_exp;
        s1      = s1_raw & ~s0;
        d       = p + (64 + h) * (s + 2) + 1;
        v_end   = p + 1 + 64 * (s + 2);
        din_end = (h != 0) ? v_end : d + 1;
        m_exp   = model_mask(s0, s1, inv, h);
        first_done = -1; n_done = 0; err_busy = 0; err_vcc = 0; err_din = 0;
        set_fault(w, s0, s1, inv);
        set_start(w, 1'b1);
        for (int e = 0; e <= d + 2; e++) begin
            @(negedge CLK);
            if ((!held && e == 0) || (held && e == d + 1)) set_start(w, 1'b0);
            sample(w, busy, done, vcc, gnd, pass, din, mask, cnt);
            idx = (e - p - 1) / (s + 2);
            if (idx > 63) idx = 63;
            din_exp = (e > p && e < din_end) ? 6'(idx) : 6'd0;
            vcc_exp = (h != 0) ? (e < v_end) : (e < d);
            if (busy !== (e < d)) err_busy++;
            if (vcc !== vcc_exp)  err_vcc++;
            if (din !== din_exp)  err_din++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = e;
            end
        end
        check_val("done_edge",   32'(first_done), 32'(d));
        check_val("done_pulses", 32'(n_done),     32'd1);
        check_val("busy_errs",   32'(err_busy),   32'd0);
        check_val("vcc_errs",    32'(err_vcc),    32'd0);
        check_val("din_errs",    32'(err_din),    32'd0);
        check_val("gnd",         32'(gnd),        32'd0);
        check_val("fail_mask",   32'(mask),       32'(m_exp));
        check_val("pass",        32'(pass),       32'(m_exp == 6'd0));
        check_val("vec_count",   32'(cnt),        32'd64);
    endtask

    task automatic reset_abort_check();
        logic busy, done, vcc, gnd, pass;
        logic [5:0] din, mask;
        logic [6:0] cnt;
        int stray;
        stray = 0;
        set_fault(0, 6'b000100, 6'd0, 1'b0);
        a_start = 1'b1;
        for (int e = 0; e <= 109; e++) begin
            @(negedge CLK);
            if (e == 0) a_start = 1'b0;
            if (e == 99) begin
                sample(0, busy, done, vcc, gnd, pass, din, mask, cnt);
                check_val("pre_reset_mask", 32'(mask), 32'(6'b000100));
                RESET = 1'b1;
            end
            if (e == 100) begin
                check_reset_values(0, "abort");
                RESET = 1'b0;
            end
            if (e > 100 && (a_done === 1'b1 || a_busy === 1'b1)) stray++;
        end
        check_val("post_reset_idle", 32'(stray), 32'd0);
        run_check(0, 4, 2, 1, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] s0, s1;
        logic       inv, held;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_values(0, "rst_a");
        check_reset_values(1, "rst_b");
        RESET = 1'b0;
        @(negedge CLK);

        run_check(0, 4, 2, 1, 6'd0,       6'd0, 1'b0, 1'b0);
        run_check(0, 4, 2, 1, 6'b001000,  6'd0, 1'b0, 1'b0);
        run_check(0, 4, 2, 1, 6'd0,       6'd0, 1'b1, 1'b0);
        run_check(0, 4, 2, 1, 6'd0,       6'd0, 1'b0, 1'b1);
        run_check(0, 4, 2, 1, 6'd0,       6'd0, 1'b0, 1'b0);
        reset_abort_check();

        for (int r = 0; r < 4; r++) begin
            s0   = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            s1   = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            inv  = 1'($urandom_range(0, 1));
            held = 1'($urandom_range(0, 1));
            run_check(0, 4, 2, 1, s0, s1, inv, held);
        end

        run_check(1, 4, 0, 0, 6'd0, 6'd0, 1'b0, 1'b0);
        run_check(1, 4, 0, 0, 6'd0, 6'd0, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            s0   = 6'($urandom_range(0, 63));
            s1   = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            inv  = 1'($urandom_range(0, 1));
            held = 1'($urandom_range(0, 1));
            run_check(1, 4, 0, 0, s0, s1, inv, held);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sn7404_test_sequencer.md
# sn7404_test_sequencer

Sequencing controller for the SN7404 hex inverter model. On a START request it powers the device, drives all 64 input patterns onto the six inverter inputs and checks each output against the inverted input. It then runs an unpowered hold check and reports pass/fail with a per-gate failure mask. It sits in the bench layer between a top-level test manager and one SN7404 socket, and owns the socket's power and input pins.

## Interface
Parameters:
- POWER_CYCLES, 4: cycles VCC is applied before the first vector (≥1).
- SETTLE_CYCLES, 2: wait cycles between driving a vector and sampling outputs (≥0).
- HOLD_CHECK, 1: 1 runs the unpowered hold check after the vectors; 0 skips it.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  run request; sampled only in IDLE.
- DUT_VCC  out  1  to socket pin 14.
- DUT_GND  out  1  to socket pin 7; always 0.
- DUT_IN  out  6  bit0..5 drive pins 1, 3, 5, 9, 11, 13.
- DUT_OUT  in  6  bit0..5 from pins 2, 4, 6, 8, 10, 12.
- BUSY  out  1  high from START acceptance until the DONE cycle, exclusive.
- DONE  out  1  one-cycle completion pulse.
- PASS  out  1  result; valid from DONE, held until the next accepted START.
- FAIL_MASK  out  6  sticky per-gate mismatch bits.
- VEC_COUNT  out  7  vectors checked, 0..64.

## Operation
- Reset values: DUT_VCC=0, DUT_GND=0, DUT_IN=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, VEC_COUNT=0. State is IDLE.
- States: IDLE, POWER, DRIVE, SETTLE, CHECK, HOLD_DRIVE, HOLD_SETTLE, HOLD_CHECK_S, DONE.
- IDLE: START=1 moves to POWER. On acceptance, clears FAIL_MASK, VEC_COUNT, PASS and the vector counter, and sets BUSY=1 and DUT_VCC=1.
- POWER: holds for POWER_CYCLES cycles, then moves to DRIVE.
- DRIVE (1 cycle): registers DUT_IN = vector (6-bit counter, starting at 0).
- SETTLE: lasts SETTLE_CYCLES cycles; skipped when the parameter is 0.
- CHECK (1 cycle):
  - Compares DUT_OUT with ~vector using case-inequality, so X or Z on an output bit counts as a mismatch.
  - ORs mismatched bits into FAIL_MASK and increments VEC_COUNT.
  - If vector=63, the counter wraps to 0 and the state moves to HOLD_DRIVE (HOLD_CHECK=1) or DONE (HOLD_CHECK=0). Otherwise the vector increments and the state returns to DRIVE.
- HOLD_DRIVE (1 cycle): DUT_VCC=0, DUT_IN=6'b000000.
- HOLD_SETTLE: lasts SETTLE_CYCLES cycles.
- HOLD_CHECK_S (1 cycle):
  - Expects DUT_OUT === 6'b000000, the value retained from vector 63 since an unpowered device must hold its outputs.
  - ORs mismatches into FAIL_MASK; VEC_COUNT is not incremented.
- DONE (1 cycle): DONE=1, BUSY=0, DUT_VCC=0, PASS = (FAIL_MASK==0), including any bits set in this same cycle's merge. Then moves to IDLE with DUT_IN=0.
- START outside IDLE is ignored, including during the DONE cycle.
- RESET wins over START in the same cycle.
- RESET mid-run forces all reset values on the next edge and aborts the run; no DONE pulse is produced.
- FAIL_MASK and VEC_COUNT hold their final values in IDLE until the next accepted START.

## Timing
- START sampled high at edge 0: BUSY and DUT_VCC go high after edge 0.
- Vector period = SETTLE_CYCLES+2 cycles. The first DUT_IN change occurs at edge POWER_CYCLES+1.
- DONE is high for exactly the one cycle following edge POWER_CYCLES + (64+HOLD_CHECK)·(SETTLE_CYCLES+2) + 1. With default parameters that is edge 265.
- DUT_IN is stable for SETTLE_CYCLES+1 edges before each CHECK sample.
- Back-to-back runs: the earliest re-accepted START is in the IDLE cycle following DONE.

## Test plan
- Ideal SN7404 on the socket, defaults, START at edge 0 -> DONE at edge 265, PASS=1, FAIL_MASK=6'b000000, VEC_COUNT=64.
- Pin 8 forced to 0 (gate 3 stuck-at-0) -> PASS=0, FAIL_MASK=6'b001000, VEC_COUNT=64.
- Socket replaced by a pure combinational inverter that ignores power -> vectors all pass; hold check sees 6'b111111, giving FAIL_MASK=6'b111111 and PASS=0.
- RESET pulsed at edge 100 of a run -> next cycle all outputs at reset values with no DONE. A new START at edge 110 gives DONE at edge 375 with PASS=1.
- START held high through an entire run -> exactly one DONE pulse per run. A second run starts only from the IDLE cycle after DONE, and START during BUSY or DONE has no effect.
- SETTLE_CYCLES=0, HOLD_CHECK=0, POWER_CYCLES=4 -> DONE at edge 133, DUT_VCC stays 1 until DONE, VEC_COUNT=64.
